sram_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer for the single-port sRAM (8-bit address, 8-bit data, en/rd/wt controls). Requester 0 (instruction fetch) and requester 1 (load/store unit) share the memory through a req/ack handshake. The arbiter owns every sRAM control, address and data-in line and returns read data to the winning requester.

---
 rtl/sram_arbiter.sv | 129 ++++++++++++
 tb/tb_sram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin two-requester arbiter and access sequencer for a single-port sRAM
// Every output is a register; the combinational block only computes next-cycle values.
module sram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_rd,
  output logic          mem_wt,
  output logic [AW-1:0] mem_add,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, ACK} state_t;

  state_t        state, state_n;
  logic          ptr, ptr_n;
  logic          win, win_n;
  logic          pick1;
  logic          en_n, rd_n, wt_n;
  logic [AW-1:0] add_n;
  logic [DW-1:0] din_n;
  logic          ack0_n, ack1_n, busy_n;
  logic [DW-1:0] rdata0_n, rdata1_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      win     <= 1'b0;
      mem_en  <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wt  <= 1'b0;
      mem_add <= '0;
      mem_din <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      win     <= win_n;
      mem_en  <= en_n;
      mem_rd  <= rd_n;
      mem_wt  <= wt_n;
      mem_add <= add_n;
      mem_din <= din_n;
      ack0    <= ack0_n;
      ack1    <= ack1_n;
      rdata0  <= rdata0_n;
      rdata1  <= rdata1_n;
      busy    <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    win_n    = win;
    en_n     = mem_en;
    rd_n     = mem_rd;
    wt_n     = mem_wt;
    add_n    = mem_add;
    din_n    = mem_din;
    ack0_n   = 1'b0;
    ack1_n   = 1'b0;
    rdata0_n = rdata0;
    rdata1_n = rdata1;
    pick1    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // ptr only matters on contention; it always points away from the last winner
          pick1   = req1 && (!req0 || ptr);
          win_n   = pick1;
          ptr_n   = !pick1;
          en_n    = 1'b1;
          wt_n    = pick1 ? we1 : we0;
          rd_n    = pick1 ? !we1 : !we0;
          add_n   = pick1 ? addr1 : addr0;
          din_n   = pick1 ? wdata1 : wdata0;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        en_n = 1'b0;
        rd_n = 1'b0;
        wt_n = 1'b0;
        // mem_wt still holds the direction of the access being performed this cycle
        if (mem_wt) begin
          ack0_n  = !win;
          ack1_n  = win;
          state_n = ACK;
        end else begin
          state_n = RDWAIT;
        end
      end
      RDWAIT: begin
        if (win) rdata1_n = mem_dout;
        else     rdata0_n = mem_dout;
        ack0_n  = !win;
        ack1_n  = win;
        state_n = ACK;
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
// Directed vector table, hand-written corner sequences, then random traffic against a cycle-level model.
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       rst, req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       ack0, ack1, busy, mem_en, mem_rd, mem_wt;
  logic [7:0] rdata0, rdata1, mem_add, mem_din;
  logic [7:0] mem_dout = 8'h00;
  logic [7:0] sram [256] = '{default: 8'h00};

  int         checks = 0;
  int         errors = 0;
  logic [7:0] lastr [2];

  always #5 clk = ~clk;

  sram_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .mem_en(mem_en), .mem_rd(mem_rd), .mem_wt(mem_wt),
    .mem_add(mem_add), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // sRAM behaviour: write on en&wt, registered read data on en&rd
  always @(posedge clk) begin
    if (mem_en && mem_wt) sram[mem_add] <= mem_din;
    if (mem_en && mem_rd) mem_dout <= sram[mem_add];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int id, input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    if (id == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  function automatic logic get_ack(input int id);
    return (id == 0) ? ack0 : ack1;
  endfunction

  function automatic logic [7:0] get_rdata(input int id);
    return (id == 0) ? rdata0 : rdata1;
  endfunction

  function automatic logic [7:0] raddr();
    return ($urandom % 4 == 0) ? 8'hFF : 8'($urandom % 8);
  endfunction

  typedef struct {
    int         id;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd;
    int         lat;
  } vec_t;

  // One isolated transaction; called and returns just after a falling edge.
  task automatic do_txn(input vec_t v);
    int k, en_cnt;
    bit got;
    k = 0; en_cnt = 0; got = 0;
    drive(v.id, 1'b1, v.we, v.addr, v.wdata);
    while (!got && k < 12) begin
      @(negedge clk);
      k++;
      chk("txn_busy", 32'(busy), 32'(1'b1));
      chk("txn_other_ack", 32'(get_ack(1 - v.id)), 32'(1'b0));
      if (mem_en) begin
        en_cnt++;
        chk("txn_mem_add", 32'(mem_add), 32'(v.addr));
        chk("txn_mem_wt", 32'(mem_wt), 32'(v.we));
        chk("txn_mem_rd", 32'(mem_rd), 32'(!v.we));
        if (v.we) chk("txn_mem_din", 32'(mem_din), 32'(v.wdata));
      end
      if (get_ack(v.id)) got = 1;
    end
    chk("txn_latency", 32'(k), 32'(v.lat));
    if (!v.we) lastr[v.id] = v.rd;
    chk("txn_rdata", 32'(get_rdata(v.id)), 32'(lastr[v.id]));
    chk("txn_rdata_other", 32'(get_rdata(1 - v.id)), 32'(lastr[1 - v.id]));
    // requester sees ack on this edge and drops req just after it
    @(posedge clk);
    #1 drive(v.id, 1'b0, v.we, v.addr, v.wdata);
    @(negedge clk);
    chk("txn_idle_busy", 32'(busy), 32'(1'b0));
    chk("txn_idle_ack", 32'({ack1, ack0}), 32'(2'b00));
    chk("txn_idle_en", 32'(mem_en), 32'(1'b0));
    @(negedge clk);
    chk("txn_no_dup_en", 32'(mem_en), 32'(1'b0));
    chk("txn_en_pulses", 32'(en_cnt), 32'(1));
  endtask

  // random-phase reference model state
  int         t, m_free, m_ack, m_grant;
  logic       m_ptr, m_win, m_we, rs, e_en;
  logic [7:0] m_addr, m_wdata;
  logic [1:0] e_ack;
  logic       e_busy;
  logic [7:0] e_rdata [2];
  logic [7:0] mref [256];

  initial begin
    vec_t vecs [9];
    int   order [4];
    int   n, k, id;
    logic r;

    vecs[0] = '{0, 1'b1, 8'h14, 8'h07, 8'h00, 2};
    vecs[1] = '{0, 1'b0, 8'h14, 8'h00, 8'h07, 3};
    vecs[2] = '{1, 1'b1, 8'h01, 8'h01, 8'h00, 2};
    vecs[3] = '{1, 1'b1, 8'h02, 8'h02, 8'h00, 2};
    vecs[4] = '{0, 1'b0, 8'h00, 8'h5C, 8'h00, 3};
    vecs[5] = '{1, 1'b0, 8'h02, 8'h00, 8'h02, 3};
    vecs[6] = '{0, 1'b1, 8'hFF, 8'hAA, 8'h00, 2};
    vecs[7] = '{0, 1'b0, 8'hFF, 8'h00, 8'hAA, 3};
    vecs[8] = '{1, 1'b0, 8'hFF, 8'h00, 8'hAA, 3};

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    lastr[0] = 8'h00;
    lastr[1] = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_ack", 32'({ack1, ack0}), 32'(2'b00));
    chk("reset_busy", 32'(busy), 32'(1'b0));
    chk("reset_mem_ctl", 32'({mem_en, mem_rd, mem_wt}), 32'(3'b000));
    chk("reset_mem_add", 32'(mem_add), 32'(8'h00));
    chk("reset_mem_din", 32'(mem_din), 32'(8'h00));
    chk("reset_rdata", 32'({rdata1, rdata0}), 32'(16'h0000));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) do_txn(vecs[i]);

    // reset while a read sits in RDWAIT
    drive(0, 1'b1, 1'b0, 8'h14, 8'h00);
    @(negedge clk);
    chk("rstmid_access", 32'({mem_en, mem_rd}), 32'(2'b11));
    @(negedge clk);
    chk("rstmid_rdwait_busy", 32'(busy), 32'(1'b1));
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h14, 8'h00);
    @(negedge clk);
    chk("rstmid_ack", 32'({ack1, ack0}), 32'(2'b00));
    chk("rstmid_busy", 32'(busy), 32'(1'b0));
    chk("rstmid_mem_ctl", 32'({mem_en, mem_rd, mem_wt}), 32'(3'b000));
    chk("rstmid_mem_add", 32'(mem_add), 32'(8'h00));
    chk("rstmid_rdata", 32'({rdata1, rdata0}), 32'(16'h0000));
    lastr[0] = 8'h00;
    lastr[1] = 8'h00;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_no_late_ack", 32'({ack1, ack0}), 32'(2'b00));

    // contention with both reqs held: ptr was reset, so 0 must win first
    drive(0, 1'b1, 1'b0, 8'h14, 8'h00);
    drive(1, 1'b1, 1'b0, 8'hFF, 8'h00);
    for (int i = 0; i < 4; i++) order[i] = -1;
    n = 0; k = 0;
    while (n < 4 && k < 40) begin
      @(negedge clk);
      k++;
      chk("cont_overlap", 32'(ack0 & ack1), 32'(1'b0));
      if (ack0 || ack1) begin
        id = ack1 ? 1 : 0;
        order[n] = id;
        n++;
        lastr[id] = (id == 0) ? 8'h07 : 8'hAA;
        chk("cont_rdata", 32'(get_rdata(id)), 32'(lastr[id]));
      end
    end
    chk("cont_count", 32'(n), 32'(4));
    for (int i = 0; i < 4; i++) chk("cont_order", 32'(order[i]), 32'(i % 2));
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 8'h14, 8'h00);
    drive(1, 1'b0, 1'b0, 8'hFF, 8'h00);
    @(negedge clk);
    chk("cont_idle", 32'(busy), 32'(1'b0));
    @(negedge clk);

    do_txn('{1, 1'b0, 8'hFF, 8'h00, 8'hAA, 3});

    // random traffic against the transaction-level model
    for (int i = 0; i < 256; i++) mref[i] = sram[i];
    rst = 1'b1;
    t = 0; m_free = 0; m_ack = -1; m_grant = -1;
    m_ptr = 1'b0; m_win = 1'b0; m_we = 1'b0; m_addr = 8'h00; m_wdata = 8'h00;
    e_ack = 2'b00; e_rdata[0] = 8'h00; e_rdata[1] = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      t++;
      rs = rst;
      if (rs) begin
        // a write in its ACCESS cycle still lands in the sRAM
        if (m_ack == t && m_we) mref[m_addr] = m_wdata;
        m_free = t + 1; m_ptr = 1'b0; m_ack = -1; m_grant = -1;
        e_ack = 2'b00; e_rdata[0] = 8'h00; e_rdata[1] = 8'h00;
      end else begin
        e_ack = 2'b00;
        if (t == m_ack) begin
          e_ack[m_win] = 1'b1;
          if (m_we) mref[m_addr] = m_wdata;
          else      e_rdata[m_win] = mref[m_addr];
        end
        if (t >= m_free && (req0 || req1)) begin
          m_win   = (req0 && req1) ? m_ptr : req1;
          m_ptr   = !m_win;
          m_we    = m_win ? we1 : we0;
          m_addr  = m_win ? addr1 : addr0;
          m_wdata = m_win ? wdata1 : wdata0;
          m_grant = t;
          m_ack   = t + (m_we ? 1 : 2);
          m_free  = m_ack + 2;
        end
      end
      e_busy = (t < m_free - 1);
      e_en   = !rs && (t == m_grant);
      @(negedge clk);
      chk("rnd_ack0", 32'(ack0), 32'(e_ack[0]));
      chk("rnd_ack1", 32'(ack1), 32'(e_ack[1]));
      chk("rnd_rdata0", 32'(rdata0), 32'(e_rdata[0]));
      chk("rnd_rdata1", 32'(rdata1), 32'(e_rdata[1]));
      chk("rnd_busy", 32'(busy), 32'(e_busy));
      chk("rnd_mem_en", 32'(mem_en), 32'(e_en));
      chk("rnd_mem_wt", 32'(mem_wt), 32'(e_en && m_we));
      chk("rnd_mem_rd", 32'(mem_rd), 32'(e_en && !m_we));
      if (e_en) begin
        chk("rnd_mem_add", 32'(mem_add), 32'(m_addr));
        chk("rnd_mem_din", 32'(mem_din), 32'(m_wdata));
      end
      if (rst) rst = 1'b0;
      else if ($urandom % 100 == 0) rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
        r = (i == 0) ? req0 : req1;
        if (e_ack[i]) begin
          if ($urandom % 2 == 0) drive(i, 1'b1, 1'($urandom), raddr(), 8'($urandom));
          else                   drive(i, 1'b0, 1'b0, 8'h00, 8'h00);
        end else if (!r) begin
          if ($urandom % 100 < 30) drive(i, 1'b1, 1'($urandom), raddr(), 8'($urandom));
        end else if (m_grant >= 0 && int'(m_win) == i && t >= m_grant && t < m_ack) begin
          // scramble the in-flight requester's inputs; the latched access must not notice
          if ($urandom % 2 == 0) drive(i, 1'b1, 1'($urandom), raddr(), 8'($urandom));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
